multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequencing control FSM for the multicycle version of the RV32 core: it replaces the single-cycle combinational control unit, letting one shared memory, one ALU and the register file be reused across several cycles per instruction. It decodes the latched instruction fields, steps through fetch/decode/execute/memory/writeback states, and drives every datapath mux select and write enable. A memory-ready handshake stretches the memory-access states.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Op  in  7  opcode field of instruction register (Instr[6:0])
- funct3  in  3  Instr[14:12]
- funct7  in  7  Instr[31:25]; only bit 5 is used
- Zero  in  1  ALU zero flag
- MemReady  in  1  shared memory completes current access this cycle
- PCWrite  out  1  PC register load enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register and OldPC load enable
- ResultSrc  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 register A
- ALUSrcB  out  2  00 register B, 01 ImmExt, 10 constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
- Illegal  out  1  sticky: unsupported opcode decoded
- State  out  4  current state encoding, for debug/verification

## Operation
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, ILLEGAL 11.
- Transitions: FETCH→DECODE when MemReady, else stay. DECODE→MEMADR (lw/sw), EXECUTER, EXECUTEI, BEQ, JAL, or ILLEGAL for any other Op. MEMADR→MEMREAD (lw) / MEMWRITE (sw). MEMREAD→MEMWB when MemReady. MEMWRITE→FETCH when MemReady. EXECUTER/EXECUTEI/JAL→ALUWB. MEMWB/ALUWB/BEQ→FETCH. ILLEGAL: absorbing until rst.
- Outputs per state (unlisted signals 0; ALUOp is internal):
  - FETCH: AdrSrc 0, IRWrite=MemReady, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10, PCWrite=MemReady.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (branch target into ALUOut).
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - MEMWRITE: AdrSrc 1, MemWrite 1 held until MemReady.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10. EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, PCWrite=Zero.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCWrite 1.
  - ILLEGAL: all enables 0, Illegal 1.
- ALU decode: ALUOp 00→add, 01→sub, 10→by funct3: 000 sub if Op[5]&funct7[5] else add; 010 slt; 110 or; 111 and; other funct3→add.
- ImmSrc decoded combinationally from Op in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.

## Timing
- Registered state only; all outputs combinational from State, Op, funct3, funct7, Zero, MemReady (Mealy qualification on PCWrite, IRWrite).
- rst asserted: State=FETCH immediately, Illegal=0; outputs show FETCH values gated by MemReady. Reset mid-instruction abandons it; no partial RegWrite/MemWrite after rst rises.
- Cycles with MemReady tied 1: beq 3, R/I/sw/jal 4, lw 5. Each MemReady-low cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- Op/funct fields are sampled only as stable IR outputs; IR changes only on IRWrite.

## Structure
- Shared package/header: state encodings, opcode constants, ALUControl codes, ALUOp codes, ImmSrc codes; reused by datapath and bench.
- One sub-module: alu_decoder (ALUOp, funct3, Op[5], funct7[5] → ALUControl). FSM and ImmSrc decode stay in the top.

## Test plan
- rst pulse mid-MEMWB (lw) → State=0 same cycle, RegWrite 0, Illegal 0.
- R-type sub (Op 0110011, funct3 000, funct7 0100000), MemReady=1 → states 0,1,6,8,0; ALUControl 001 in EXECUTER; RegWrite only in ALUWB.
- lw with MemReady low 2 cycles in FETCH and 1 in MEMREAD → 8 cycles total; PCWrite/IRWrite pulse once, on ready cycle only.
- beq Zero=1 vs Zero=0 → PCWrite 1 vs 0 in state 9; ALUControl 001; return to FETCH.
- jal → states 0,1,10,8; ImmSrc 11; PCWrite 1 in JAL; RegWrite in ALUWB.
- Op 0110111 (unsupported) → State 11, Illegal 1 held for 10 cycles, no enables; cleared only by rst.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module : multicycle_controller_pkg
// Brief  : Shared encodings for the multicycle RV32 control path.
// Rev    : 1.0  initial release
// ============================================================================
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] C_OP_LW    = 7'b0000011;
  localparam logic [6:0] C_OP_SW    = 7'b0100011;
  localparam logic [6:0] C_OP_RTYPE = 7'b0110011;
  localparam logic [6:0] C_OP_ITYPE = 7'b0010011;
  localparam logic [6:0] C_OP_BEQ   = 7'b1100011;
  localparam logic [6:0] C_OP_JAL   = 7'b1101111;

  localparam logic [2:0] C_ALU_ADD = 3'b000;
  localparam logic [2:0] C_ALU_SUB = 3'b001;
  localparam logic [2:0] C_ALU_AND = 3'b010;
  localparam logic [2:0] C_ALU_OR  = 3'b011;
  localparam logic [2:0] C_ALU_SLT = 3'b101;

  localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] C_IMM_I = 2'b00;
  localparam logic [1:0] C_IMM_S = 2'b01;
  localparam logic [1:0] C_IMM_B = 2'b10;
  localparam logic [1:0] C_IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      C_OP_SW:  imm_src = C_IMM_S;
      C_OP_BEQ: imm_src = C_IMM_B;
      C_OP_JAL: imm_src = C_IMM_J;
      default:  imm_src = C_IMM_I;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module : alu_decoder
// Brief  : Maps ALUOp and instruction function fields to an ALU operation.
// Rev    : 1.0  initial release
// ============================================================================
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = C_ALU_ADD;
    case (alu_op_i)
      C_ALUOP_SUB: alu_control_o = C_ALU_SUB;
      C_ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type carries a real funct7; I-type reuses those bits as immediate
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? C_ALU_SUB : C_ALU_ADD;
          3'b010:  alu_control_o = C_ALU_SLT;
          3'b110:  alu_control_o = C_ALU_OR;
          3'b111:  alu_control_o = C_ALU_AND;
          default: alu_control_o = C_ALU_ADD;
        endcase
      end
      default: alu_control_o = C_ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module : multicycle_controller
// Brief  : Sequencing FSM driving the shared-memory multicycle RV32 datapath.
// Rev    : 1.0  initial release
// ============================================================================
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] alu_op;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          C_OP_LW, C_OP_SW: state_d = S_MEMADR;
          C_OP_RTYPE:       state_d = S_EXECUTER;
          C_OP_ITYPE:       state_d = S_EXECUTEI;
          C_OP_BEQ:         state_d = S_BEQ;
          C_OP_JAL:         state_d = S_JAL;
          default:          state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (Op == C_OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ:       state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    alu_op    = C_ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        // PC+4 computed and written through ALUResult while memory returns the word
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = C_ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = C_ALUOP_FUNCT;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = C_ALUOP_SUB;
        PCWrite = Zero;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (Op[5]),
    .funct7b5_i    (funct7[5]),
    .alu_control_o (ALUControl)
  );

  assign ImmSrc  = imm_src(Op);
  assign Illegal = (state_q == S_ILLEGAL);
  assign State   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_multicycle_controller
// Brief  : Directed scoreboard bench for the multicycle control FSM.
// Rev    : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic       clk, rst, Zero, MemReady;
  logic [6:0] Op, funct7;
  logic [2:0] funct3;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  logic [6:0] op_s, f7_s;
  logic [2:0] f3_s;
  logic       rst_s;

  logic [20:0] exp_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad   = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .Illegal(Illegal), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs {State,PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,RegWrite,ImmSrc,Illegal}
  function automatic logic [20:0] mk(input logic [3:0] st, input logic pcw, input logic adr,
                                     input logic mw, input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] alu, input logic rw,
                                     input logic [1:0] imm, input logic ill);
    return {st, pcw, adr, mw, irw, rs, sa, sb, alu, rw, imm, ill};
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    op_s = op; f3_s = f3; f7_s = f7;
  endtask

  task automatic step(input string nm, input logic mr, input logic z, input logic [20:0] e);
    @(posedge clk);
    #1;
    rst = rst_s; Op = op_s; funct3 = f3_s; funct7 = f7_s; MemReady = mr; Zero = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [20:0] e, got;
      string nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, RegWrite, ImmSrc, Illegal};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got=%h expected=%h", nm, got, e);
      end
    end
  end

  initial begin
    rst = 1'b1; Op = 7'd0; funct3 = 3'd0; funct7 = 7'd0; Zero = 1'b0; MemReady = 1'b0;
    rst_s = 1'b1;
    set_instr(7'd0, 3'd0, 7'd0);
    step("reset", N, N, mk(4'd0, N, N, N, N, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b00, N));
    rst_s = 1'b0;

    // R-type sub
    set_instr(7'b0110011, 3'b000, 7'b0100000);
    step("sub_fetch",  Y, N, mk(4'd0, Y, N, N, Y, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b00, N));
    step("sub_decode", Y, N, mk(4'd1, N, N, N, N, 2'b00, 2'b01, 2'b01, 3'b000, N, 2'b00, N));
    step("sub_exec",   Y, N, mk(4'd6, N, N, N, N, 2'b00, 2'b10, 2'b00, 3'b001, N, 2'b00, N));
    step("sub_wb",     Y, N, mk(4'd8, N, N, N, N, 2'b00, 2'b00, 2'b00, 3'b000, Y, 2'b00, N));

    // ori
    set_instr(7'b0010011, 3'b110, 7'b0000000);
    step("ori_fetch",  Y, N, mk(4'd0, Y, N, N, Y, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b00, N));
    step("ori_decode", Y, N, mk(4'd1, N, N, N, N, 2'b00, 2'b01, 2'b01, 3'b000, N, 2'b00, N));
    step("ori_exec",   Y, N, mk(4'd7, N, N, N, N, 2'b00, 2'b10, 2'b01, 3'b011, N, 2'b00, N));
    step("ori_wb",     Y, N, mk(4'd8, N, N, N, N, 2'b00, 2'b00, 2'b00, 3'b000, Y, 2'b00, N));

    // addi whose immediate sets bit 30: must stay add
    set_instr(7'b0010011, 3'b000, 7'b0100000);
    step("addi_fetch",  Y, N, mk(4'd0, Y, N, N, Y, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b00, N));
    step("addi_decode", Y, N, mk(4'd1, N, N, N, N, 2'b00, 2'b01, 2'b01, 3'b000, N, 2'b00, N));
    step("addi_exec",   Y, N, mk(4'd7, N, N, N, N, 2'b00, 2'b10, 2'b01, 3'b000, N, 2'b00, N));
    step("addi_wb",     Y, N, mk(4'd8, N, N, N, N, 2'b00, 2'b00, 2'b00, 3'b000, Y, 2'b00, N));

    // lw with wait states
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    step("lw_fetch_w0", N, N, mk(4'd0, N, N, N, N, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b00, N));
    step("lw_fetch_w1", N, N, mk(4'd0, N, N, N, N, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b00, N));
    step("lw_fetch",    Y, N, mk(4'd0, Y, N, N, Y, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b00, N));
    step("lw_decode",   Y, N, mk(4'd1, N, N, N, N, 2'b00, 2'b01, 2'b01, 3'b000, N, 2'b00, N));
    step("lw_memadr",   Y, N, mk(4'd2, N, N, N, N, 2'b00, 2'b10, 2'b01, 3'b000, N, 2'b00, N));
    step("lw_read_w",   N, N, mk(4'd3, N, Y, N, N, 2'b00, 2'b00, 2'b00, 3'b000, N, 2'b00, N));
    step("lw_read",     Y, N, mk(4'd3, N, Y, N, N, 2'b00, 2'b00, 2'b00, 3'b000, N, 2'b00, N));
    step("lw_memwb",    Y, N, mk(4'd4, N, N, N, N, 2'b01, 2'b00, 2'b00, 3'b000, Y, 2'b00, N));

    // sw with one write wait state
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    step("sw_fetch",   Y, N, mk(4'd0, Y, N, N, Y, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b01, N));
    step("sw_decode",  Y, N, mk(4'd1, N, N, N, N, 2'b00, 2'b01, 2'b01, 3'b000, N, 2'b01, N));
    step("sw_memadr",  Y, N, mk(4'd2, N, N, N, N, 2'b00, 2'b10, 2'b01, 3'b000, N, 2'b01, N));
    step("sw_write_w", N, N, mk(4'd5, N, Y, Y, N, 2'b00, 2'b00, 2'b00, 3'b000, N, 2'b01, N));
    step("sw_write",   Y, N, mk(4'd5, N, Y, Y, N, 2'b00, 2'b00, 2'b00, 3'b000, N, 2'b01, N));

    // beq taken then not taken
    set_instr(7'b1100011, 3'b000, 7'b0000000);
    step("beq1_fetch",  Y, N, mk(4'd0, Y, N, N, Y, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b10, N));
    step("beq1_decode", Y, N, mk(4'd1, N, N, N, N, 2'b00, 2'b01, 2'b01, 3'b000, N, 2'b10, N));
    step("beq1_taken",  Y, Y, mk(4'd9, Y, N, N, N, 2'b00, 2'b10, 2'b00, 3'b001, N, 2'b10, N));
    step("beq0_fetch",  Y, N, mk(4'd0, Y, N, N, Y, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b10, N));
    step("beq0_decode", Y, N, mk(4'd1, N, N, N, N, 2'b00, 2'b01, 2'b01, 3'b000, N, 2'b10, N));
    step("beq0_not",    Y, N, mk(4'd9, N, N, N, N, 2'b00, 2'b10, 2'b00, 3'b001, N, 2'b10, N));

    // jal
    set_instr(7'b1101111, 3'b000, 7'b0000000);
    step("jal_fetch",  Y, N, mk(4'd0,  Y, N, N, Y, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b11, N));
    step("jal_decode", Y, N, mk(4'd1,  N, N, N, N, 2'b00, 2'b01, 2'b01, 3'b000, N, 2'b11, N));
    step("jal_jal",    Y, N, mk(4'd10, Y, N, N, N, 2'b00, 2'b01, 2'b10, 3'b000, N, 2'b11, N));
    step("jal_wb",     Y, N, mk(4'd8,  N, N, N, N, 2'b00, 2'b00, 2'b00, 3'b000, Y, 2'b11, N));

    // lw abandoned by reset during MEMWB
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    step("lwr_fetch",  Y, N, mk(4'd0, Y, N, N, Y, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b00, N));
    step("lwr_decode", Y, N, mk(4'd1, N, N, N, N, 2'b00, 2'b01, 2'b01, 3'b000, N, 2'b00, N));
    step("lwr_memadr", Y, N, mk(4'd2, N, N, N, N, 2'b00, 2'b10, 2'b01, 3'b000, N, 2'b00, N));
    step("lwr_read",   Y, N, mk(4'd3, N, Y, N, N, 2'b00, 2'b00, 2'b00, 3'b000, N, 2'b00, N));
    rst_s = 1'b1;
    step("lwr_rst",    N, N, mk(4'd0, N, N, N, N, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b00, N));
    rst_s = 1'b0;
    step("lwr_after",  N, N, mk(4'd0, N, N, N, N, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b00, N));

    // unsupported opcode (lui)
    set_instr(7'b0110111, 3'b000, 7'b0000000);
    step("ill_fetch",  Y, N, mk(4'd0, Y, N, N, Y, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b00, N));
    step("ill_decode", Y, N, mk(4'd1, N, N, N, N, 2'b00, 2'b01, 2'b01, 3'b000, N, 2'b00, N));
    for (int i = 0; i < 10; i++)
      step("ill_hold", Y, Y, mk(4'd11, N, N, N, N, 2'b00, 2'b00, 2'b00, 3'b000, N, 2'b00, Y));
    rst_s = 1'b1;
    step("ill_rst",   Y, N, mk(4'd0, Y, N, N, Y, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b00, N));
    rst_s = 1'b0;
    step("ill_clear", N, N, mk(4'd0, N, N, N, N, 2'b10, 2'b00, 2'b10, 3'b000, N, 2'b00, N));

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
